// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - shared types and constants for the EXE-stage issue sequencer
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] CMD_NOP  = 4'd15;
    localparam logic [3:0] MC_FIRST = 4'd9;
    localparam logic [3:0] MC_LAST  = 4'd12;
    localparam logic [5:0] OPC_MAX  = 6'd12;

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - op-in and completion-out handshakes of the issue sequencer
interface exec_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_cmd;
    logic             out_illegal;

    modport master (
        output in_valid, in_opcode, in_tag, out_ready,
        input  in_ready, out_valid, out_tag, out_cmd, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_tag, out_ready,
        output in_ready, out_valid, out_tag, out_cmd, out_illegal
    );
endinterface

// File: rtl/exec_sequencer_cmd_decode.sv
// rtl/exec_sequencer_cmd_decode.sv - opcode to ALU command decode with multi-cycle/illegal flags
module exec_cmd_decode
    import exec_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] cmd,
    output logic       is_multi,
    output logic       illegal
);
    always_comb begin
        illegal  = (opcode > OPC_MAX);
        cmd      = illegal ? CMD_NOP : opcode[3:0];
        is_multi = !illegal && (cmd >= MC_FIRST) && (cmd <= MC_LAST);
    end
endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - issues decoded ops to the ALU, holds multi-cycle cmds, returns completion records
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int TAG_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    exec_if.slave       bus,
    output logic        alu_en,
    output logic [3:0]  alu_cmd,
    output logic        busy,
    output logic [15:0] op_count
);
    localparam int CNT_W = $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cmd_q, dec_cmd;
    logic [TAG_W-1:0] tag_q;
    logic             ill_q, multi_q, dec_multi, dec_ill;
    logic             load, handshake;

    exec_cmd_decode u_decode (
        .opcode   (bus.in_opcode),
        .cmd      (dec_cmd),
        .is_multi (dec_multi),
        .illegal  (dec_ill)
    );

    assign bus.in_ready    = !flush && ((state == IDLE) || ((state == RESP) && bus.out_ready));
    assign load            = bus.in_valid && bus.in_ready;
    assign handshake       = (state == RESP) && bus.out_ready && !flush;
    assign bus.out_tag     = tag_q;
    assign bus.out_cmd     = cmd_q;
    assign bus.out_illegal = ill_q;

    // Illegal ops bypass ISSUE and go straight to the response slot.
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (load) state_d = dec_ill ? RESP : ISSUE;
                ISSUE:   state_d = multi_q ? WAIT : RESP;
                WAIT:    if (cnt == '0) state_d = RESP;
                RESP: begin
                    if (load)                state_d = dec_ill ? RESP : ISSUE;
                    else if (bus.out_ready)  state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_q         <= '0;
            tag_q         <= '0;
            ill_q         <= 1'b0;
            multi_q       <= 1'b0;
            alu_en        <= 1'b0;
            alu_cmd       <= '0;
            busy          <= 1'b0;
            bus.out_valid <= 1'b0;
            op_count      <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                cmd_q   <= dec_cmd;
                tag_q   <= bus.in_tag;
                ill_q   <= dec_ill;
                multi_q <= dec_multi;
            end
            if (state == ISSUE)
                cnt <= CNT_LOAD;
            else if ((state == WAIT) && (cnt != '0))
                cnt <= cnt - 1'b1;
            alu_en        <= (state_d == ISSUE) || (state_d == WAIT);
            alu_cmd       <= ((state_d == ISSUE) || (state_d == WAIT)) ? (load ? dec_cmd : cmd_q) : 4'd0;
            busy          <= (state_d != IDLE);
            bus.out_valid <= (state_d == RESP);
            if (handshake)
                op_count <= op_count + 16'd1;
        end
    end
endmodule
